board_input_conditioner: RTL

Conditions the raw FPGA board inputs (GO push-button, reset push-button, PINXUAN switch, DATA_CHOICE switches) before they reach the CPU, in the opposite direction from the display-driving NA/SEG path. Each input is synchronised into S_CLK and debounced. The block emits clean levels plus a single-cycle GO pulse and a change strobe. It sits in the board top level between the input pins and the CPU's GO/RST/pinxuan/data_choice ports.

---
 rtl/board_io_pkg.sv | 15 +
 rtl/debounce_chan.sv | 92 +++++++++
 rtl/board_input_conditioner.sv | 80 ++++++++
 3 files changed

// File: rtl/board_io_pkg.sv
// Shared constants and debounce state encoding for the board input path.
package board_io_pkg;

  localparam int unsigned DB_CNT_DEF = 500000;
  localparam int unsigned CNT_W_DEF  = 24;

  // Encoding is {stable, pending}.
  typedef enum logic [1:0] {
    DB_IDLE_LO = 2'b00,
    DB_PEND_HI = 2'b01,
    DB_IDLE_HI = 2'b10,
    DB_PEND_LO = 2'b11
  } db_state_e;

endpackage : board_io_pkg

// File: rtl/debounce_chan.sv
// One input channel: 2-flop synchroniser, debounce counter and edge pulses.
module debounce_chan
  import board_io_pkg::*;
#(
  parameter int unsigned DB_CNT = DB_CNT_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic S_CLK,
  input  logic RST,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

  logic             r_s1;
  logic             r_s2;
  db_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;
  logic             r_fall;

  db_state_e        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  always_ff @(posedge S_CLK) begin
    if (!RST) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= DB_IDLE_LO;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1    <= raw;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // A sample matching the accepted value always restarts the count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      DB_IDLE_LO, DB_PEND_HI: begin
        if (!r_s2) begin
          w_state_nxt = DB_IDLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = DB_IDLE_HI;
          w_cnt_nxt   = '0;
          w_rise_nxt  = 1'b1;
        end else begin
          w_state_nxt = DB_PEND_HI;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      DB_IDLE_HI, DB_PEND_LO: begin
        if (r_s2) begin
          w_state_nxt = DB_IDLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = DB_IDLE_LO;
          w_cnt_nxt   = '0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_state_nxt = DB_PEND_LO;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = DB_IDLE_LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign level = (r_state == DB_IDLE_HI) || (r_state == DB_PEND_LO);
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule : debounce_chan

// File: rtl/board_input_conditioner.sv
// Synchronises and debounces the board buttons/switches feeding the CPU.
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int unsigned DB_CNT = DB_CNT_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic       S_CLK,
  input  logic       RST,
  input  logic       GO_IN,
  input  logic       RSTBTN_IN,
  input  logic       PINXUAN_IN,
  input  logic [1:0] DATA_CHOICE_IN,
  output logic       GO,
  output logic       GO_LEVEL,
  output logic       RST_OUT,
  output logic       PINXUAN,
  output logic [1:0] DATA_CHOICE,
  output logic       CHG
);

  logic w_go_rise, w_go_fall;
  logic w_rb_rise, w_rb_fall;
  logic w_px_rise, w_px_fall;
  logic w_dc0_rise, w_dc0_fall;
  logic w_dc1_rise, w_dc1_fall;
  logic w_unused_edges;

  debounce_chan #(.DB_CNT(DB_CNT), .CNT_W(CNT_W)) u_go (
    .S_CLK (S_CLK),
    .RST   (RST),
    .raw   (GO_IN),
    .level (GO_LEVEL),
    .rise  (w_go_rise),
    .fall  (w_go_fall)
  );

  debounce_chan #(.DB_CNT(DB_CNT), .CNT_W(CNT_W)) u_rstbtn (
    .S_CLK (S_CLK),
    .RST   (RST),
    .raw   (RSTBTN_IN),
    .level (RST_OUT),
    .rise  (w_rb_rise),
    .fall  (w_rb_fall)
  );

  debounce_chan #(.DB_CNT(DB_CNT), .CNT_W(CNT_W)) u_pinxuan (
    .S_CLK (S_CLK),
    .RST   (RST),
    .raw   (PINXUAN_IN),
    .level (PINXUAN),
    .rise  (w_px_rise),
    .fall  (w_px_fall)
  );

  debounce_chan #(.DB_CNT(DB_CNT), .CNT_W(CNT_W)) u_dc0 (
    .S_CLK (S_CLK),
    .RST   (RST),
    .raw   (DATA_CHOICE_IN[0]),
    .level (DATA_CHOICE[0]),
    .rise  (w_dc0_rise),
    .fall  (w_dc0_fall)
  );

  debounce_chan #(.DB_CNT(DB_CNT), .CNT_W(CNT_W)) u_dc1 (
    .S_CLK (S_CLK),
    .RST   (RST),
    .raw   (DATA_CHOICE_IN[1]),
    .level (DATA_CHOICE[1]),
    .rise  (w_dc1_rise),
    .fall  (w_dc1_fall)
  );

  // Pulses come straight from channel flops, so they line up with the levels.
  assign GO  = w_go_rise;
  assign CHG = w_px_rise | w_px_fall | w_dc0_rise | w_dc0_fall | w_dc1_rise | w_dc1_fall;

  assign w_unused_edges = w_go_fall ^ w_rb_rise ^ w_rb_fall;

endmodule : board_input_conditioner
